// File: rtl/bist_prpg_ctrl_if.sv
// Scan-side handshake of the logic-BIST pattern generator: launch request in,
// scan-in data, scan enable and run status out.
interface bist_prpg_ctrl_if #(
  parameter int CHAIN_NUM = 11,
  parameter int PAT_NUM   = 100
);
  logic                         start;
  logic [CHAIN_NUM-1:0]         sc_in;
  logic                         test_se;
  logic                         busy;
  logic                         done;
  logic [$clog2(PAT_NUM+1)-1:0] pat_cnt;

  modport master (output start, input sc_in, test_se, busy, done, pat_cnt);
  modport slave  (input start, output sc_in, test_se, busy, done, pat_cnt);
endinterface

// File: rtl/bist_prpg_ctrl.sv
// Logic-BIST PRPG: 13-bit Fibonacci LFSR feeding the scan chains plus the
// shift/capture sequencer. Optional phase shifter on sc_in: PRPG_PHASE_SHIFT_EN.
module bist_prpg_ctrl #(
  parameter int                  CHAIN_NUM = 11,
  parameter int                  PRPG_LEN  = 13,
  parameter int                  CHAIN_LEN = 32,
  parameter int                  PAT_NUM   = 100,
  parameter logic [PRPG_LEN-1:0] SEED      = 13'h1070
) (
  input logic              clk,
  input logic              rst,
  bist_prpg_ctrl_if.slave  bus
);
  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PW = $clog2(PAT_NUM + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_UNLOAD  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [PRPG_LEN-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]       shift_cnt_q, shift_cnt_d;
  logic [PW-1:0]       pat_cnt_q, pat_cnt_d;
  logic [PW-1:0]       pat_cnt_inc;
  logic                test_se;
  logic                fb;
  logic                last_shift;

  assign test_se     = (state_q == S_SHIFT) || (state_q == S_UNLOAD);
  assign fb          = lfsr_q[PRPG_LEN-1] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
  assign last_shift  = (shift_cnt_q == CW'(CHAIN_LEN - 1));
  assign pat_cnt_inc = pat_cnt_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = test_se ? {lfsr_q[PRPG_LEN-2:0], fb} : lfsr_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE keeps the final LFSR/pat_cnt visible until the next launch
        if (bus.start) begin
          state_d     = S_SHIFT;
          lfsr_d      = SEED;
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
        end
      end
      S_SHIFT, S_UNLOAD: begin
        if (last_shift) begin
          shift_cnt_d = '0;
          state_d     = (state_q == S_SHIFT) ? S_CAPTURE : S_DONE;
        end else begin
          shift_cnt_d = shift_cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        pat_cnt_d = pat_cnt_inc;
        state_d   = (pat_cnt_inc == PW'(PAT_NUM)) ? S_UNLOAD : S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
    end
  end

  for (genvar i = 0; i < CHAIN_NUM; i++) begin : g_sc
`ifdef PRPG_PHASE_SHIFT_EN
    assign bus.sc_in[i] = lfsr_q[i] ^ lfsr_q[(i + 5) % PRPG_LEN];
`else
    assign bus.sc_in[i] = lfsr_q[i];
`endif
  end

  assign bus.test_se = test_se;
  assign bus.busy    = (state_q == S_SHIFT) || (state_q == S_CAPTURE) || (state_q == S_UNLOAD);
  assign bus.done    = (state_q == S_DONE);
  assign bus.pat_cnt = pat_cnt_q;
endmodule

// File: tb/tb_bist_prpg_ctrl.sv
// Directed bench for bist_prpg_ctrl with CHAIN_LEN=4, PAT_NUM=3.
module tb_bist_prpg_ctrl;
  localparam int          CHAIN_NUM = 11;
  localparam int          CHAIN_LEN = 4;
  localparam int          PAT_NUM   = 3;
  localparam logic [12:0] SEED      = 13'h1070;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [12:0] m;
  logic [18:0] pat;

  always #5 clk = ~clk;

  bist_prpg_ctrl_if #(.CHAIN_NUM(CHAIN_NUM), .PAT_NUM(PAT_NUM)) bif ();

  bist_prpg_ctrl #(
    .CHAIN_NUM(CHAIN_NUM), .PRPG_LEN(13), .CHAIN_LEN(CHAIN_LEN),
    .PAT_NUM(PAT_NUM), .SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  function automatic logic [12:0] lfsr_next(input logic [12:0] x);
    return {x[11:0], x[12] ^ x[3] ^ x[2] ^ x[0]};
  endfunction

  function automatic logic [10:0] sc_exp(input logic [12:0] x);
    logic [10:0] r;
    for (int i = 0; i < 11; i++) begin
`ifdef PRPG_PHASE_SHIFT_EN
      r[i] = x[i] ^ x[(i + 5) % 13];
`else
      r[i] = x[i];
`endif
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walks n cycles of a run starting at pattern index k0, checking every output.
  task automatic run_cycles(input int k0, input int n);
    int caps;
    caps = 0;
    for (int k = 0; k < k0; k++) if (!pat[18-k]) caps++;
    for (int k = k0; k < k0 + n; k++) begin
      check("test_se", 32'(bif.test_se), 32'(pat[18-k]));
      check("busy",    32'(bif.busy), 32'd1);
      check("done",    32'(bif.done), 32'd0);
      check("pat_cnt", 32'(bif.pat_cnt), 32'(caps));
      check("sc_in",   32'(bif.sc_in), 32'(sc_exp(m)));
      if (pat[18-k]) m = lfsr_next(m);
      else caps++;
      step();
    end
  endtask

  initial begin
    pat = 19'b1111_0_1111_0_1111_0_1111;
    rst = 1'b1;
    bif.start = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    check("rst_test_se", 32'(bif.test_se), 32'd0);
    check("rst_busy",    32'(bif.busy), 32'd0);
    check("rst_done",    32'(bif.done), 32'd0);
    check("rst_pat_cnt", 32'(bif.pat_cnt), 32'd0);
`ifdef PRPG_PHASE_SHIFT_EN
    check("rst_sc_in",   32'(bif.sc_in), 32'h0F3);
`else
    check("rst_sc_in",   32'(bif.sc_in), 32'h070);
`endif
    step();
    check("idle_hold_se", 32'(bif.test_se), 32'd0);

    // full run from a one-cycle start pulse
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    m = SEED;
    run_cycles(0, 1);
`ifndef PRPG_PHASE_SHIFT_EN
    check("first_step_sc", 32'(bif.sc_in), 32'h0E1);
`endif
    run_cycles(1, 18);
    check("done_flag",    32'(bif.done), 32'd1);
    check("done_busy",    32'(bif.busy), 32'd0);
    check("done_test_se", 32'(bif.test_se), 32'd0);
    check("done_pat_cnt", 32'(bif.pat_cnt), 32'd3);
    step();
    check("done_hold",    32'(bif.done), 32'd1);
    check("done_hold_sc", 32'(bif.sc_in), 32'(sc_exp(m)));
    check("done_hold_pc", 32'(bif.pat_cnt), 32'd3);

    // start held high: relaunch from DONE with reloaded LFSR, no mid-run restart
    bif.start = 1'b1;
    step();
    m = SEED;
    run_cycles(0, 19);
    check("gate_done",    32'(bif.done), 32'd1);
    check("gate_pat_cnt", 32'(bif.pat_cnt), 32'd3);
    step();
    check("relaunch_se",   32'(bif.test_se), 32'd1);
    check("relaunch_busy", 32'(bif.busy), 32'd1);
    check("relaunch_pc",   32'(bif.pat_cnt), 32'd0);
    check("relaunch_sc",   32'(bif.sc_in), 32'(sc_exp(SEED)));
    bif.start = 1'b0;

    // reset during shift cycle 2 of pattern 2
    m = SEED;
    run_cycles(0, 6);
    check("mid_se", 32'(bif.test_se), 32'd1);
    check("mid_pc", 32'(bif.pat_cnt), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_test_se", 32'(bif.test_se), 32'd0);
    check("mrst_busy",    32'(bif.busy), 32'd0);
    check("mrst_done",    32'(bif.done), 32'd0);
    check("mrst_pat_cnt", 32'(bif.pat_cnt), 32'd0);
    check("mrst_sc_in",   32'(bif.sc_in), 32'(sc_exp(SEED)));

    // reset beats a simultaneous start
    rst = 1'b1;
    bif.start = 1'b1;
    step();
    rst = 1'b0;
    bif.start = 1'b0;
    check("rst_win_busy", 32'(bif.busy), 32'd0);
    check("rst_win_se",   32'(bif.test_se), 32'd0);
    step();
    check("idle_stay",    32'(bif.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
